alu_op_issuer: RTL

//  Driver side of the alu port contract: accepts one MIPS R-type instruction plus two

---
 rtl/alu_pkg.sv | 37 +++
 rtl/rtype_decoder.sv | 53 +++++
 rtl/alu_op_issuer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issuer: alu func codes, MIPS R-type opcode/funct
// values and the issuer FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE   = 6'h00;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // Wide enough for the largest legal latency (4).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational MIPS R-type decode: instruction word to alu func, shift amount,
// destination register and a legality flag.
module rtype_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic        legal,
  output logic [2:0]  func,
  output logic [4:0]  shamt,
  output logic [4:0]  rd
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] shamt_field;

  // rs/rt fields carry no meaning here; operands arrive already read.
  logic unused_fields;
  assign unused_fields = ^instr[25:16];

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign shamt_field = instr[10:6];
  assign rd          = instr[15:11];

  always_comb begin
    legal = 1'b0;
    func  = ALU_ADD;
    shamt = 5'd0;
    if (op == OP_RTYPE) begin
      case (funct)
        FUNCT_ADD, FUNCT_ADDU: begin legal = 1'b1; func = ALU_ADD; end
        FUNCT_SUB, FUNCT_SUBU: begin legal = 1'b1; func = ALU_SUB; end
        FUNCT_AND:             begin legal = 1'b1; func = ALU_AND; end
        FUNCT_OR:              begin legal = 1'b1; func = ALU_OR;  end
        FUNCT_XOR:             begin legal = 1'b1; func = ALU_XOR; end
        FUNCT_SLT:             begin legal = 1'b1; func = ALU_SLT; end
        FUNCT_SLL: begin
          legal = 1'b1;
          func  = ALU_SLL;
          shamt = shamt_field;
        end
        FUNCT_SRL: begin
          legal = 1'b1;
          func  = ALU_SRL;
          shamt = shamt_field;
        end
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one R-type operation at a time to a clocked alu, waits out its latency
// and returns the captured result with its destination tag.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_func,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_err_q, out_err_d;
  logic [DATA_W-1:0]   out_res_q, out_res_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [2:0]          alu_func_q, alu_func_d;
  logic [4:0]          alu_shamt_q, alu_shamt_d;

  logic                dec_legal;
  logic [2:0]          dec_func;
  logic [4:0]          dec_shamt;
  logic [4:0]          dec_rd;

  rtype_decoder u_decoder (
    .instr (in_instr),
    .legal (dec_legal),
    .func  (dec_func),
    .shamt (dec_shamt),
    .rd    (dec_rd)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_res_d   = out_res_q;
    out_tag_d   = out_tag_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    alu_shamt_d = alu_shamt_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          out_tag_d  = TAG_W'(dec_rd);
          if (dec_legal) begin
            alu_a_d     = in_a;
            alu_b_d     = in_b;
            alu_func_d  = dec_func;
            alu_shamt_d = dec_shamt;
            cnt_d       = CNT_W'(ALU_LAT);
            state_d     = WAIT;
          end else begin
            // Illegal ops never reach the alu; its inputs keep their last values.
            out_res_d   = '0;
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        out_res_d   = alu_res;
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // No bypass: a new op is only accepted once back in IDLE.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      alu_shamt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_res_q   <= out_res_d;
      out_tag_q   <= out_tag_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      alu_shamt_q <= alu_shamt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_func  = alu_func_q;
  assign alu_shamt = alu_shamt_q;

endmodule
